// File: rtl/dmem_pkg.sv
// Shared types for the data-memory DMA controller: engine state encoding and
// transfer mode constants.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dma_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dmem_dma_ctrl.sv
// Data-memory port owner: the core has absolute priority, and a byte-wide
// copy/fill engine uses the port only in cycles the core leaves free.
module dmem_dma_ctrl
  import dmem_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         CoreAccess,
  input  logic         CoreWriteEn,
  input  logic [A-1:0] CoreAddr,
  input  logic [W-1:0] CoreDataIn,
  output logic [W-1:0] CoreDataOut,
  input  logic         Start,
  input  logic         Mode,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A:0]   Len,
  input  logic [W-1:0] FillVal,
  output logic         Busy,
  output logic         Done,
  output logic         MemWriteEn,
  output logic [A-1:0] MemAddr,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut
);

  dma_state_t   state_q;
  logic [A-1:0] src_q;
  logic [A-1:0] dst_q;
  logic [A:0]   cnt_q;
  logic         mode_q;
  logic [W-1:0] buf_q;
  logic         busy_q;
  logic         done_q;

  // The engine only moves in cycles where the core leaves the port free.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            src_q  <= SrcAddr;
            dst_q  <= DstAddr;
            cnt_q  <= Len;
            mode_q <= Mode;
            busy_q <= 1'b1;
            if (Mode == MODE_FILL) buf_q <= FillVal;
            if (Len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= (Mode == MODE_FILL) ? WR : RD;
            end
          end
        end
        RD: begin
          if (!CoreAccess) begin
            buf_q   <= MemDataOut;
            src_q   <= src_q + A'(1);
            state_q <= WR;
          end
        end
        WR: begin
          if (!CoreAccess) begin
            dst_q <= dst_q + A'(1);
            cnt_q <= cnt_q - (A+1)'(1);
            if (cnt_q == (A+1)'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (mode_q == MODE_COPY) begin
              state_q <= RD;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Port mux: the core always wins; an idle or stalled engine parks on dst/buf.
  always_comb begin
    MemWriteEn = 1'b0;
    MemAddr    = dst_q;
    MemDataIn  = buf_q;
    if (CoreAccess) begin
      MemWriteEn = CoreWriteEn;
      MemAddr    = CoreAddr;
      MemDataIn  = CoreDataIn;
    end else if (state_q == RD) begin
      MemAddr = src_q;
    end else if (state_q == WR) begin
      MemWriteEn = 1'b1;
    end
  end

  assign CoreDataOut = MemDataOut;
  assign Busy        = busy_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_dmem_dma_ctrl.sv
// Bench for dmem_dma_ctrl: behavioural memory, reference memory image and a
// queue of expected engine writes compared as the engine strobes the port.
module tb_dmem_dma_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       CoreAccess, CoreWriteEn;
  logic [7:0] CoreAddr, CoreDataIn, CoreDataOut;
  logic       Start, Mode;
  logic [7:0] SrcAddr, DstAddr;
  logic [8:0] Len;
  logic [7:0] FillVal;
  logic       Busy, Done;
  logic       MemWriteEn;
  logic [7:0] MemAddr, MemDataIn, MemDataOut;

  dmem_dma_ctrl #(.W(8), .A(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .CoreAccess(CoreAccess), .CoreWriteEn(CoreWriteEn),
    .CoreAddr(CoreAddr), .CoreDataIn(CoreDataIn), .CoreDataOut(CoreDataOut),
    .Start(Start), .Mode(Mode), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .Len(Len), .FillVal(FillVal), .Busy(Busy), .Done(Done),
    .MemWriteEn(MemWriteEn), .MemAddr(MemAddr), .MemDataIn(MemDataIn),
    .MemDataOut(MemDataOut)
  );

  always #5 Clk = ~Clk;

  // Single-port memory: synchronous write, combinational read.
  logic [7:0] mem [256] = '{default: 8'h00};
  always @(posedge Clk) if (MemWriteEn) mem[MemAddr] <= MemDataIn;
  assign MemDataOut = mem[MemAddr];

  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t        exp_q[$];
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int         n_checks = 0;
  int         n_errors = 0;
  int         done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Done) done_cnt++;
    if (CoreAccess) begin
      check_eq("core_addr", MemAddr, CoreAddr);
      check_eq("core_we", MemWriteEn, CoreWriteEn);
      check_eq("core_din", MemDataIn, CoreDataIn);
    end else begin
      if (!Busy) check_eq("idle_we", MemWriteEn, 1'b0);
      if (MemWriteEn) begin
        check_eq("wr_pending", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check_eq("wr_addr", MemAddr, e.a);
          check_eq("wr_data", MemDataIn, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic core_wr(input logic [7:0] a, input logic [7:0] d);
    CoreAccess = 1'b1; CoreWriteEn = 1'b1; CoreAddr = a; CoreDataIn = d;
    ref_mem[a] = d;
    tick();
    CoreAccess = 1'b0; CoreWriteEn = 1'b0;
  endtask

  task automatic core_rd(input string tag, input logic [7:0] a);
    CoreAccess = 1'b1; CoreWriteEn = 1'b0; CoreAddr = a;
    @(negedge Clk);
    check_eq(tag, CoreDataOut, ref_mem[a]);
    tick();
    CoreAccess = 1'b0;
  endtask

  // Drives one Start strobe and queues the first push_n bytes it should write.
  task automatic start_xfer(input logic mode, input logic [7:0] src, input logic [7:0] dst,
                            input logic [8:0] len, input logic [7:0] fv, input int push_n);
    logic [7:0] sa, da, v;
    sa = src; da = dst;
    for (int i = 0; i < push_n; i++) begin
      v = mode ? fv : ref_mem[sa];
      ref_mem[da] = v;
      exp_q.push_back(wr_t'{a: da, d: v});
      sa++; da++;
    end
    Start = 1'b1; Mode = mode; SrcAddr = src; DstAddr = dst; Len = len; FillVal = fv;
    tick();
    Start = 1'b0;
    check_eq("busy_after_start", Busy, 1'b1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!Done && n < 400) begin
      tick();
      n++;
    end
    check_eq("done_seen", Done, 1'b1);
  endtask

  task automatic post_idle();
    tick();
    check_eq("post_busy", Busy, 1'b0);
    check_eq("post_done", Done, 1'b0);
  endtask

  int n, n2, d0;

  initial begin
    Reset = 1'b1; CoreAccess = 1'b0; CoreWriteEn = 1'b0; CoreAddr = '0; CoreDataIn = '0;
    Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0; FillVal = '0;
    tick(); tick();
    check_eq("rst_busy", Busy, 1'b0);
    check_eq("rst_done", Done, 1'b0);
    Reset = 1'b0;
    tick();

    // Whole-memory fill, starting mid-array so the address wraps.
    start_xfer(1'b1, 8'h00, 8'h37, 9'd256, 8'h3C, 256);
    wait_done(n);
    check_eq("len256_cycles", n, 256);
    post_idle();
    core_rd("len256_rd36", 8'h36);
    core_rd("len256_rd00", 8'h00);

    start_xfer(1'b1, 8'h00, 8'h10, 9'd4, 8'hA5, 4);
    wait_done(n);
    check_eq("fill_cycles", n, 4);
    post_idle();
    for (int i = 0; i < 4; i++) core_rd("fill_rd", 8'h10 + 8'(i));

    core_wr(8'h20, 8'h11); core_wr(8'h21, 8'h22); core_wr(8'h22, 8'h33);
    start_xfer(1'b0, 8'h20, 8'h40, 9'd3, 8'h00, 3);
    wait_done(n);
    check_eq("copy_cycles", n, 6);
    post_idle();
    for (int i = 0; i < 3; i++) core_rd("copy_rd", 8'h40 + 8'(i));

    // Core holds the port for 3 cycles in the middle of a copy.
    start_xfer(1'b0, 8'h20, 8'h90, 9'd3, 8'h00, 3);
    CoreAccess = 1'b1; CoreWriteEn = 1'b1; CoreAddr = 8'h80; CoreDataIn = 8'h5A;
    ref_mem[8'h80] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("prio_busy", Busy, 1'b1);
    end
    CoreAccess = 1'b0; CoreWriteEn = 1'b0;
    wait_done(n2);
    check_eq("prio_cycles", 3 + n2, 9);
    post_idle();
    core_rd("prio_rd80", 8'h80);
    for (int i = 0; i < 3; i++) core_rd("prio_rd", 8'h90 + 8'(i));

    start_xfer(1'b1, 8'h00, 8'hFE, 9'd3, 8'hC3, 3);
    wait_done(n);
    check_eq("wrap_cycles", n, 3);
    post_idle();
    core_rd("wrap_rdFD", 8'hFD);
    core_rd("wrap_rdFE", 8'hFE);
    core_rd("wrap_rdFF", 8'hFF);
    core_rd("wrap_rd00", 8'h00);
    core_rd("wrap_rd01", 8'h01);

    d0 = done_cnt;
    start_xfer(1'b1, 8'h00, 8'h70, 9'd0, 8'hEE, 0);
    wait_done(n);
    check_eq("len0_cycles", n, 0);
    post_idle();
    check_eq("len0_pulses", done_cnt - d0, 1);
    core_rd("len0_rd70", 8'h70);

    // A second Start during a fill must be ignored.
    d0 = done_cnt;
    start_xfer(1'b1, 8'h00, 8'h50, 9'd6, 8'h77, 6);
    tick(); tick();
    Start = 1'b1; Mode = 1'b0; SrcAddr = 8'h20; DstAddr = 8'h60; Len = 9'd2;
    tick();
    Start = 1'b0;
    wait_done(n2);
    check_eq("busy_start_cycles", 3 + n2, 6);
    post_idle();
    tick(); tick();
    check_eq("busy_start_pulses", done_cnt - d0, 1);
    core_rd("busy_start_rd60", 8'h60);
    core_rd("busy_start_rd61", 8'h61);
    core_rd("busy_start_rd55", 8'h55);

    // Reset while the engine is reading byte 2 of a 5-byte copy.
    for (int i = 0; i < 5; i++) core_wr(8'hA0 + 8'(i), 8'(i + 1));
    d0 = done_cnt;
    start_xfer(1'b0, 8'hA0, 8'hB0, 9'd5, 8'h00, 2);
    tick(); tick(); tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_eq("rst_mid_busy", Busy, 1'b0);
    check_eq("rst_mid_done", Done, 1'b0);
    @(negedge Clk);
    check_eq("rst_mid_we", MemWriteEn, 1'b0);
    tick();
    check_eq("rst_mid_pulses", done_cnt - d0, 0);
    for (int i = 0; i < 5; i++) core_rd("rst_mid_rd", 8'hB0 + 8'(i));

    start_xfer(1'b1, 8'h00, 8'hB2, 9'd2, 8'h99, 2);
    wait_done(n);
    check_eq("after_rst_cycles", n, 2);
    post_idle();
    core_rd("after_rst_rdB2", 8'hB2);
    core_rd("after_rst_rdB3", 8'hB3);
    core_rd("after_rst_rdB4", 8'hB4);

    check_eq("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_dma_ctrl.md
Name: dmem_dma_ctrl

Overview:
- Owns the address/data/write-enable inputs of the single-port, 2**A-deep data memory.
- Shares that port between the processor core (fixed highest priority) and an internal block-transfer engine.
- The engine performs memory-to-memory copy or constant fill, one byte per granted cycle.
- Sits between the register-file/decoder datapath and the data memory. Software starts transfers through a start strobe plus config ports.

Parameters:
W, 8, data width in bits
A, 8, address width in bits; memory depth 2**A

Ports:
Clk  input  1  clock
Reset  input  1  synchronous, active-high reset
CoreAccess  input  1  core uses memory this cycle (read or write)
CoreWriteEn  input  1  core write strobe; qualified by CoreAccess
CoreAddr  input  A  core address
CoreDataIn  input  W  core write data
CoreDataOut  output  W  read data to core; equals MemDataOut
Start  input  1  one-cycle transfer start strobe
Mode  input  1  0 = copy, 1 = fill
SrcAddr  input  A  copy source base
DstAddr  input  A  destination base
Len  input  A+1  byte count, 0..2**A
FillVal  input  W  fill constant
Busy  output  1  transfer in progress
Done  output  1  one-cycle pulse at transfer completion
MemWriteEn  output  1  to memory WriteEn
MemAddr  output  A  to memory DataAddress
MemDataIn  output  W  to memory DataIn
MemDataOut  input  W  from memory DataOut (combinational read)

Behaviour:
- States: IDLE, RD, WR, DONE. Registers: src, dst (A bits), cnt (A+1 bits), mode, buf (W bits).
- Reset: state=IDLE; all registers 0; Busy=0, Done=0.
- Reset mid-transfer aborts immediately. There is no Done pulse, and bytes already written stay written.
- Port mux, combinational:
  - CoreAccess=1 → MemAddr=CoreAddr, MemDataIn=CoreDataIn, MemWriteEn=CoreWriteEn.
  - Otherwise the engine drives the port. When the engine is idle or stalled: MemWriteEn=0, MemAddr=dst, MemDataIn=buf.
- CoreDataOut = MemDataOut at all times.
- Grant: the engine advances only in cycles with CoreAccess=0. In a cycle with CoreAccess=1 it holds state, and no engine strobe reaches memory.
- IDLE:
  - Start=1 latches SrcAddr, DstAddr, Len, Mode.
  - If Mode=1, buf←FillVal.
  - Next state: Len==0 → DONE; Mode=0 → RD; Mode=1 → WR.
  - Busy=0 in IDLE only.
- RD (copy only), when granted:
  - MemAddr=src; buf←MemDataOut.
  - src←src+1 (mod 2**A); next state WR.
- WR, when granted:
  - MemAddr=dst, MemDataIn=buf, MemWriteEn=1.
  - dst←dst+1 (mod 2**A); cnt←cnt−1.
  - If cnt==1 → DONE; else → RD (copy) or stay in WR (fill).
- DONE: Done=1 for exactly this cycle; Busy=1; next state IDLE unconditionally, regardless of CoreAccess.
- Start is ignored whenever state≠IDLE.
- Throughput, uncontended: copy = 2 cycles/byte, fill = 1 cycle/byte. Completion latency = Start cycle + (2·Len or Len) + 1 DONE cycle.
- Addresses wrap modulo 2**A. Len=2**A covers the whole memory.
- Overlapping src/dst copies proceed ascending, so byte-wise forward copy semantics apply.
- No coherence with core accesses to an in-flight region. Software must avoid them.

Decomposition:
- Package dmem_pkg: enum dma_state_t {IDLE, RD, WR, DONE}; localparams MODE_COPY=1'b0, MODE_FILL=1'b1.
- Single module; the port mux stays inline. No sub-module is needed.
- The memory is instantiated alongside this block at the top level, not inside it.

Test Plan:
- Fill, uncontended: Start, Mode=1, DstAddr=0x10, Len=4, FillVal=0xA5 → writes to 0x10..0x13 on 4 consecutive cycles; Done pulses the next cycle; readback of all four = 0xA5.
- Copy: preload 0x20..0x22 = 11,22,33; Start Mode=0, Src=0x20, Dst=0x40, Len=3 → 6 RD/WR cycles, then Done; 0x40..0x42 = 11,22,33.
- Core priority: during a copy, assert CoreAccess=1, CoreWriteEn=1, CoreAddr=0x80, CoreDataIn=0x5A for 3 cycles → memory sees only core strobes; engine state frozen; Done arrives exactly 3 cycles later than uncontended; 0x80=0x5A.
- Wrap and edge lengths:
  - Fill Dst=0xFE, Len=3 → bytes 0xFE, 0xFF, 0x00 written.
  - Len=0 → Done on the cycle after Start, with no MemWriteEn.
  - Len=256 → all 256 bytes written.
- Start while Busy: second Start mid-fill, with a different DstAddr → ignored; only the first region is modified; a single Done pulse.
- Reset mid-copy at byte 2 of 5 → next cycle Busy=0, Done=0, MemWriteEn=0; bytes 0–1 copied, bytes 2–4 untouched; a new Start works normally.
